canny_frame_ctrl: RTL and testbench
===================================

# canny_frame_ctrl

Frame sequencer placed in front of and behind the Canny pipeline. It accepts a raster pixel stream over a valid/ready handshake and drives the pipeline's free-running `pixel_in` with exactly one pixel per clock. After the last input pixel it pads with zeros so the line buffers drain. On the output side it counts the pipeline's `out_valid` beats and tags each with column, row, end-of-line and end-of-frame, then signals frame completion.

## Interface
- `IMG_W`, 256, pixels per line; must match the pipeline's `IMG_W`.
- `IMG_H`, 256, lines per frame.
- `TIMEOUT_CYC`, 8192, maximum FLUSH cycles; used only when the timeout is compiled in.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle frame start request; ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE state.
- `done`  out  1  one-cycle pulse on frame completion.
- `err`  out  2  bit0 = input underrun (sticky per frame); bit1 = flush timeout.
- `s_valid`  in  1  source pixel valid.
- `s_data`  in  8  source pixel.
- `s_ready`  out  1  controller accepts `s_data`.
- `pipe_pixel`  out  8  drives the pipeline `pixel_in`.
- `pipe_valid`  in  1  the pipeline's `out_valid`.
- `pipe_data`  in  8  the pipeline's `pixel_out`.
- `m_valid`  out  1  tagged output beat.
- `m_data`  out  8  output pixel.
- `m_col`  out  $clog2(IMG_W)  output column.
- `m_row`  out  $clog2(IMG_H)  output row.
- `m_eol`  out  1  last pixel of a line.
- `m_eof`  out  1  last pixel of the frame.

## Operation
- **FSM states:** IDLE, STREAM, FLUSH, DONE.
- **IDLE**
  - `s_ready`=0, `pipe_pixel`=0, `pipe_valid` ignored.
  - `start`=1 clears `err`, the input counter, the output counters and `out_done`, then moves to STREAM.
- **STREAM**
  - `s_ready`=1.
  - Each cycle: if `s_valid`=1, forward `s_data`; otherwise forward 0 and set `err[0]`.
  - The input counter advances every cycle regardless of `s_valid`, because the pipeline cannot stall.
  - When the counter reaches IMG_W*IMG_H-1, move to FLUSH.
- **FLUSH**
  - `s_ready`=0, `pipe_pixel`=0 every cycle.
  - When `out_done` is set, move to DONE.
- **DONE**
  - `done`=1 for one cycle, `busy`=0 on the next cycle, then return to IDLE.
- **Output side** (active in STREAM and FLUSH)
  - Each `pipe_valid`=1 with `out_done`=0 produces one `m_*` beat.
  - `m_col` increments and wraps at IMG_W-1; `m_row` increments on that wrap.
  - `m_eol` = (col == IMG_W-1).
  - `m_eof` = eol and (row == IMG_H-1); the eof beat sets the sticky `out_done`.
  - `pipe_valid` beats after `out_done` are dropped.
- **Early completion:** if `out_done` is set during STREAM, the remaining inputs are still streamed. FLUSH then lasts one cycle and goes straight to DONE.
- **Reset:** `rst` low in any state forces IDLE immediately and clears all counters and flags. Any frame in flight is abandoned with no `done` pulse.

## Timing
- **Reset values:** `busy`, `done`, `err`, `s_ready`, `pipe_pixel`, `m_valid`, `m_data`, `m_col`, `m_row`, `m_eol`, `m_eof` are all 0.
- All outputs are registered.
- `start` sampled at edge N → `s_ready`=1 and `busy`=1 from N+1.
- `s_data` accepted at edge N → on `pipe_pixel` from N+1.
- `pipe_valid` sampled at edge N → `m_*` beat at N+1.
- `done` asserts one cycle after the FLUSH cycle in which `out_done`=1 is observed.
- `start` asserted in the same cycle as `done` is ignored; a new `start` is accepted only from IDLE.
- `err` holds its value after `done` until the next accepted `start`.

## Configuration
- **`CANNY_CTRL_TIMEOUT_EN` defined:**
  - A FLUSH cycle counter runs.
  - On reaching TIMEOUT_CYC with `out_done`=0: set `err[1]`, move to DONE (normal `done` pulse), and suppress further `m_*` beats.
- **Not defined:**
  - FLUSH waits indefinitely for `out_done`.
  - `err[1]` is tied to 0.

## Test plan
All scenarios use IMG_W=8, IMG_H=4, TIMEOUT_CYC=64.
- **Nominal frame:** `s_valid` held 1, ramp data 0..31, pipeline model returns 32 beats → `s_ready` high for exactly 32 cycles; `m_eol` on cols 7; `m_eof` on beat 32 (row 3, col 7); one `done`; `err`=0.
- **Underrun:** `s_valid`=0 on input pixel 10 → `pipe_pixel`=0 in that slot; `err[0]`=1 at `done`; pixel count unchanged (still 32 `s_ready` cycles).
- **Extra beats:** model emits 40 beats → exactly 32 `m_valid` beats; beats 33..40 dropped.
- **Timeout (macro on):** model emits only 20 beats → `err[1]`=1 and `done` 64 cycles after FLUSH entry. Macro off → `busy` stays 1 and no `done` after 200 cycles.
- **Start while busy:** `start` pulsed mid-STREAM → no effect on counters; one `done` only.
- **Reset mid-frame:** `rst` low at input pixel 15 → all outputs 0 at once. A new `start` after release runs a full 32-pixel frame correctly.

Source files
------------

// File: rtl/canny_frame_ctrl.sv
// Purpose : frame sequencer around the Canny pipeline; feeds one pixel per clock, pads zeros, tags outputs.
// Latency : s_data -> pipe_pixel 1 cycle; pipe_valid/pipe_data -> m_* beat 1 cycle; done 1 cycle after out_done seen in FLUSH.
// Backpress: none toward the pipeline; s_ready is high for exactly IMG_W*IMG_H STREAM cycles, a missing s_valid is an underrun.
//
// Ports:
//   clk, rst (async active-low), start/busy/done/err  - frame control and status
//   s_valid/s_data/s_ready                            - source raster stream
//   pipe_pixel (to pipeline), pipe_valid/pipe_data    - pipeline input and output
//   m_valid/m_data/m_col/m_row/m_eol/m_eof            - tagged output beats
// Optional feature: define CANNY_CTRL_TIMEOUT_EN to bound FLUSH to TIMEOUT_CYC cycles (sets err[1]).

module canny_frame_ctrl #(
   parameter int IMG_W       = 256,
   parameter int IMG_H       = 256,
   parameter int TIMEOUT_CYC = 8192
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               err,
   input  logic                     s_valid,
   input  logic [7:0]               s_data,
   output logic                     s_ready,
   output logic [7:0]               pipe_pixel,
   input  logic                     pipe_valid,
   input  logic [7:0]               pipe_data,
   output logic                     m_valid,
   output logic [7:0]               m_data,
   output logic [$clog2(IMG_W)-1:0] m_col,
   output logic [$clog2(IMG_H)-1:0] m_row,
   output logic                     m_eol,
   output logic                     m_eof
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int PW = $clog2(IMG_W * IMG_H);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [PW-1:0] PIX_LAST = PW'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t        state;
   logic [PW-1:0] in_cnt;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic          out_done;

   logic out_en;
   logic beat_eol;
   logic beat_eof;
   logic timeout_hit;

`ifdef CANNY_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] flush_cnt;

   // Last permitted FLUSH cycle without the eof beat having arrived.
   assign timeout_hit = (state == S_FLUSH) && !out_done && (flush_cnt == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // A pipeline beat is tagged only while a frame is live and before the eof beat;
   // the timeout cycle also drops its beat so nothing is emitted after err[1].
   assign out_en   = ((state == S_STREAM) || (state == S_FLUSH)) && pipe_valid
                     && !out_done && !timeout_hit;
   assign beat_eol = (col_cnt == COL_LAST);
   assign beat_eof = beat_eol && (row_cnt == ROW_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         in_cnt     <= '0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         out_done   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 2'b00;
         s_ready    <= 1'b0;
         pipe_pixel <= 8'h00;
         m_valid    <= 1'b0;
         m_data     <= 8'h00;
         m_col      <= '0;
         m_row      <= '0;
         m_eol      <= 1'b0;
         m_eof      <= 1'b0;
`ifdef CANNY_CTRL_TIMEOUT_EN
         flush_cnt  <= '0;
`endif
      end else begin
         done    <= 1'b0;
         m_valid <= 1'b0;

         // Output side: tag and count pipeline beats.
         if (out_en) begin
            m_valid <= 1'b1;
            m_data  <= pipe_data;
            m_col   <= col_cnt;
            m_row   <= row_cnt;
            m_eol   <= beat_eol;
            m_eof   <= beat_eof;
            if (beat_eol) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
            if (beat_eof) begin
               out_done <= 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               s_ready    <= 1'b0;
               pipe_pixel <= 8'h00;
               if (start) begin
                  err      <= 2'b00;
                  in_cnt   <= '0;
                  col_cnt  <= '0;
                  row_cnt  <= '0;
                  out_done <= 1'b0;
                  busy     <= 1'b1;
                  s_ready  <= 1'b1;
                  state    <= S_STREAM;
               end
            end

            S_STREAM: begin
               // The pipeline cannot stall: a missing pixel becomes 0 and is flagged.
               pipe_pixel <= s_valid ? s_data : 8'h00;
               if (!s_valid) begin
                  err[0] <= 1'b1;
               end
               if (in_cnt == PIX_LAST) begin
                  in_cnt  <= '0;
                  s_ready <= 1'b0;
                  state   <= S_FLUSH;
`ifdef CANNY_CTRL_TIMEOUT_EN
                  flush_cnt <= '0;
`endif
               end else begin
                  in_cnt <= in_cnt + 1'b1;
               end
            end

            S_FLUSH: begin
               pipe_pixel <= 8'h00;
`ifdef CANNY_CTRL_TIMEOUT_EN
               flush_cnt <= flush_cnt + 1'b1;
               if (timeout_hit) begin
                  err[1] <= 1'b1;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end
`endif
               if (out_done) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end

            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Purpose : self-checking bench for canny_frame_ctrl at IMG_W=8, IMG_H=4, TIMEOUT_CYC=64.
// Latency : the bench stands in for the pipeline, returning a scripted run of beats after a delay.
// Backpress: source always offers data except at a chosen underrun slot.

module tb_canny_frame_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic [1:0] err;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic [7:0] pipe_pixel;
   logic       pipe_valid;
   logic [7:0] pipe_data;
   logic       m_valid;
   logic [7:0] m_data;
   logic [2:0] m_col;
   logic [1:0] m_row;
   logic       m_eol;
   logic       m_eof;

   canny_frame_ctrl #(
      .IMG_W      (8),
      .IMG_H      (4),
      .TIMEOUT_CYC(64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .pipe_pixel(pipe_pixel),
      .pipe_valid(pipe_valid),
      .pipe_data (pipe_data),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_col     (m_col),
      .m_row     (m_row),
      .m_eol     (m_eol),
      .m_eof     (m_eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int beats;
      int delay;
      int under;
      int mid;
      int exp_sready;
      int exp_mbeats;
      int exp_err;
      int exp_done_cyc;
   } vec_t;

   vec_t tbl[5];

   int checks;
   int failures;

   // Per-frame observations.
   int sready_cnt;
   int mbeat_cnt;
   int tag_err;
   int pix_err;
   int done_cnt;
   int done_cyc;
   int last_sready_cyc;
   int busy_at_done;
   int err_at_done;
   int busy_end;
   int err_end;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},       int'(busy), 0);
      check({tag, " done"},       int'(done), 0);
      check({tag, " err"},        int'(err), 0);
      check({tag, " s_ready"},    int'(s_ready), 0);
      check({tag, " pipe_pixel"}, int'(pipe_pixel), 0);
      check({tag, " m_valid"},    int'(m_valid), 0);
      check({tag, " m_data"},     int'(m_data), 0);
      check({tag, " m_col"},      int'(m_col), 0);
      check({tag, " m_row"},      int'(m_row), 0);
      check({tag, " m_eol"},      int'(m_eol), 0);
      check({tag, " m_eof"},      int'(m_eof), 0);
   endtask

   // Runs one frame: pulses start, drives the source ramp and the scripted pipeline
   // beats, and observes every cycle until two cycles past done or max_cyc.
   task automatic run_frame(input int beats, input int delay, input int under,
                            input int mid, input int max_cyc);
      int pix;
      int k;
      int exp_pp;
      int prev_sready;
      int prev_sv;
      int prev_sd;
      sready_cnt = 0; mbeat_cnt = 0; tag_err = 0; pix_err = 0;
      done_cnt = 0; done_cyc = -100; last_sready_cyc = -1;
      busy_at_done = -1; err_at_done = -1; busy_end = -1; err_end = -1;
      prev_sready = 0; prev_sv = 0; prev_sd = 0; pix = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         start      = (cyc == mid);
         s_valid    = (pix != under);
         s_data     = 8'(pix);
         pipe_valid = (cyc >= delay) && (cyc < delay + beats);
         pipe_data  = 8'((cyc - delay) * 3 + 1);
         @(negedge clk);
         exp_pp = (prev_sready != 0) ? ((prev_sv != 0) ? prev_sd : 0) : 0;
         if (int'(pipe_pixel) != exp_pp) pix_err++;
         if (s_ready) begin
            sready_cnt++;
            last_sready_cyc = cyc;
            pix++;
         end
         prev_sready = int'(s_ready);
         prev_sv     = int'(s_valid);
         prev_sd     = int'(s_data);
         if (m_valid) begin
            k = mbeat_cnt;
            if (int'(m_col) != k % 8 || int'(m_row) != (k / 8) % 4 ||
                int'(m_eol) != ((k % 8 == 7) ? 1 : 0) || int'(m_eof) != ((k == 31) ? 1 : 0) ||
                int'(m_data) != ((k * 3 + 1) & 255)) begin
               tag_err++;
            end
            mbeat_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = int'(busy);
            err_at_done  = int'(err);
         end
         busy_end = int'(busy);
         err_end  = int'(err);
         if (done_cnt > 0 && cyc == done_cyc + 2) break;
         @(posedge clk);
         #1;
      end
      start      = 1'b0;
      s_valid    = 1'b0;
      pipe_valid = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      run_frame(v.beats, v.delay, v.under, v.mid, 120);
      check({p, " sready_cycles"}, sready_cnt, v.exp_sready);
      check({p, " last_sready_cyc"}, last_sready_cyc, v.exp_sready - 1);
      check({p, " pipe_pixel_err"}, pix_err, 0);
      check({p, " m_beats"}, mbeat_cnt, v.exp_mbeats);
      check({p, " m_tag_err"}, tag_err, 0);
      check({p, " done_cnt"}, done_cnt, 1);
      check({p, " done_cyc"}, done_cyc, v.exp_done_cyc);
      check({p, " busy_at_done"}, busy_at_done, 1);
      check({p, " err_at_done"}, err_at_done, v.exp_err);
      check({p, " busy_after"}, busy_end, 0);
      check({p, " err_held"}, err_end, v.exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pix;
      int guard;
      checks = 0; failures = 0;
      //          beats delay under mid sready mbeats err done_cyc
      tbl[0] = '{32, 10, -1, -1, 32, 32, 0, 43};  // nominal
      tbl[1] = '{32,  5, 10, -1, 32, 32, 1, 38};  // underrun at pixel 10
      tbl[2] = '{40,  3, -1, -1, 32, 32, 0, 36};  // 8 extra beats dropped
      tbl[3] = '{32,  0, -1, -1, 32, 32, 0, 33};  // eof on last STREAM edge, one FLUSH cycle
      tbl[4] = '{32, 10, -1, 12, 32, 32, 0, 43};  // start pulsed mid-STREAM

      rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      pipe_valid = 1'b0; pipe_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         apply_vec(tbl[i], i);
      end

      // Reset in the middle of a frame, with beats in flight.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; s_valid = 1'b1; pipe_valid = 1'b1; pipe_data = 8'hA5;
      pix = 0; guard = 0;
      while (pix < 15 && guard < 100) begin
         s_data = 8'(pix);
         @(negedge clk);
         if (s_ready) pix++;
         guard++;
         @(posedge clk);
         #1;
      end
      check("rst_mid pixels_before_reset", pix, 15);
      check("rst_mid m_valid_before", int'(m_valid), 1);
      rst = 1'b0;
      #1;
      check_all_zero("rst_mid");
      s_valid = 1'b0; pipe_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid idle busy", int'(busy), 0);
      check("rst_mid idle s_ready", int'(s_ready), 0);
      apply_vec(tbl[0], 10);

      // Pipeline returns only 20 beats.
      run_frame(20, 5, -1, -1, 200);
      check("timeout m_beats", mbeat_cnt, 20);
      check("timeout m_tag_err", tag_err, 0);
      check("timeout sready_cycles", sready_cnt, 32);
`ifdef CANNY_CTRL_TIMEOUT_EN
      check("timeout done_cnt", done_cnt, 1);
      check("timeout done_after_flush", done_cyc - (last_sready_cyc + 1), 64);
      check("timeout err_at_done", err_at_done, 2);
      check("timeout busy_after", busy_end, 0);
`else
      check("hang done_cnt", done_cnt, 0);
      check("hang busy", busy_end, 1);
      check("hang err", err_end, 0);
      rst = 1'b0;
      #1;
      check_all_zero("hang_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
